ram_loader: RTL and testbench

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader.sv | 130 +++++++++++++
 tb/tb_ram_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// ram_loader: host-to-RAM byte loader.
// A session of len+1 bytes is written to addresses 0..len. Each byte is
// taken from the host in ACCEPT, its address is set up in SETADDR, and it
// is strobed into the RAM in WRITE. All outputs are Moore-decoded from the
// registered state and the datapath registers.
module ram_loader (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic [3:0] len,
  input  logic       abort,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic [3:0] addr_out,
  output logic       addr_en,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       load,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCEPT  = 3'd1,
    S_SETADDR = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] ptr_q, ptr_d;
  logic [3:0] last_q, last_d;
  logic [7:0] byte_q, byte_d;

  // State register; reset forces IDLE immediately so a write strobe drops at once.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: byte pointer, last address of the session, held byte.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ptr_q  <= 4'd0;
      last_q <= 4'd0;
      byte_q <= 8'h00;
    end else begin
      ptr_q  <= ptr_d;
      last_q <= last_d;
      byte_q <= byte_d;
    end
  end

  // Next-state logic; abort wins over everything in the three active states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_ACCEPT;
      S_ACCEPT: begin
        if (abort)           state_d = S_IDLE;
        else if (byte_valid) state_d = S_SETADDR;
      end
      S_SETADDR: state_d = abort ? S_IDLE : S_WRITE;
      S_WRITE: begin
        if (abort)                state_d = S_IDLE;
        else if (ptr_q == last_q) state_d = S_DONE;
        else                      state_d = S_ACCEPT;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath next values; len is only sampled at session start, and an
  // aborted handshake leaves the held byte untouched.
  always_comb begin
    ptr_d  = ptr_q;
    last_d = last_q;
    byte_d = byte_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          last_d = len;
          ptr_d  = 4'd0;
        end
      end
      S_ACCEPT: begin
        if (!abort && byte_valid) byte_d = byte_in;
      end
      S_WRITE: begin
        // The pointer stops at last_q, so it never wraps inside a session.
        if (!abort && (ptr_q != last_q)) ptr_d = ptr_q + 4'd1;
      end
      default: ;
    endcase
  end

  // Output decode from registered state; every output is 0 outside its state.
  always_comb begin
    byte_ready = 1'b0;
    addr_out   = 4'd0;
    addr_en    = 1'b0;
    data_out   = 8'h00;
    data_oe    = 1'b0;
    load       = 1'b0;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    case (state_q)
      S_ACCEPT:  byte_ready = 1'b1;
      S_SETADDR: begin
        addr_en  = 1'b1;
        addr_out = ptr_q;
      end
      S_WRITE: begin
        addr_out = ptr_q;
        load     = 1'b1;
        data_oe  = 1'b1;
        data_out = byte_q;
      end
      S_DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_loader.sv
// Testbench for ram_loader: directed sessions plus randomized sessions,
// checked against an expected-RAM model built from the bytes the host sends.
`timescale 1ns/1ps
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       start;
  logic [3:0] len;
  logic       abort;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic [3:0] addr_out;
  logic       addr_en;
  logic [7:0] data_out;
  logic       data_oe;
  logic       load;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  ram_loader dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .start      (start),
    .len        (len),
    .abort      (abort),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .addr_out   (addr_out),
    .addr_en    (addr_en),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .load       (load),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // RAM behaviour and bus monitor: the RAM samples load on posedge clk.
  logic [7:0] tb_ram [16];
  int cyc       = 0;
  int n_load    = 0;
  int n_addr_en = 0;
  int n_done    = 0;
  int done_cyc  = 0;
  int max_addr  = 0;
  int n_bad     = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load) begin
      tb_ram[addr_out] <= data_out;
      n_load <= n_load + 1;
    end
    if (addr_en) n_addr_en <= n_addr_en + 1;
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if ((addr_en || load) && (int'(addr_out) > max_addr)) max_addr <= int'(addr_out);
    if ((!data_oe && data_out != 8'h00) || (load !== data_oe) || (addr_en && load) ||
        (!busy && (byte_ready || addr_en || load || done)))
      n_bad <= n_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_session(input logic [3:0] l, output int start_c);
    start_c = cyc;
    len   = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    len   = $urandom_range(0, 15);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) check("ready_timeout", {31'd0, byte_ready}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    wait_ready();
    repeat (stall) @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic check_ram(input string tag, input logic [7:0] exp [16]);
    for (int a = 0; a < 16; a++)
      check($sformatf("%s_ram%0d", tag, a), {24'd0, tb_ram[a]}, {24'd0, exp[a]});
  endtask

  logic [7:0] exp_ram [16];
  logic [7:0] vec4 [4];
  int sc, l0, ld0, ae0, dn0;

  initial begin
    clr_n = 1'b0; start = 1'b0; len = 4'd0; abort = 1'b0;
    byte_in = 8'h00; byte_valid = 1'b0;
    for (int a = 0; a < 16; a++) exp_ram[a] = tb_ram[a];

    // Reset state
    #3;
    check("reset_outputs", {14'd0, byte_ready, addr_out, addr_en, data_out, data_oe, load, busy, done}, 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Four-byte session, host never stalls
    vec4[0] = 8'h1E; vec4[1] = 8'h2F; vec4[2] = 8'hE0; vec4[3] = 8'hF0;
    dn0 = n_done;
    start_session(4'd3, sc);
    for (int k = 0; k < 4; k++) begin
      send_byte(vec4[k], 0);
      exp_ram[k] = vec4[k];
    end
    wait_done();
    check("s4_busy_at_done", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("s4_done_latency", done_cyc - sc, 32'd13);
    check("s4_done_count", n_done - dn0, 32'd1);
    check("s4_busy_after", {30'd0, busy, done}, 32'd0);
    check_ram("s4", exp_ram);

    // Full sixteen-byte session
    dn0 = n_done; ld0 = n_load;
    start_session(4'd15, sc);
    for (int k = 0; k < 16; k++) begin
      send_byte(8'hA0 + 8'(k), 0);
      exp_ram[k] = 8'hA0 + 8'(k);
    end
    wait_done();
    @(negedge clk);
    check("s16_loads", n_load - ld0, 32'd16);
    check("s16_done_count", n_done - dn0, 32'd1);
    check("s16_max_addr", max_addr, 32'd15);
    check_ram("s16", exp_ram);

    // Host stall in ACCEPT
    ld0 = n_load; ae0 = n_addr_en;
    start_session(4'd1, sc);
    wait_ready();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall_ready%0d", k), {31'd0, byte_ready}, 32'd1);
      @(negedge clk);
    end
    check("stall_no_addr_en", n_addr_en - ae0, 32'd0);
    check("stall_no_load", n_load - ld0, 32'd0);
    send_byte(8'h3C, 0);
    send_byte(8'hC3, 0);
    exp_ram[0] = 8'h3C; exp_ram[1] = 8'hC3;
    wait_done();
    @(negedge clk);
    check("stall_loads", n_load - ld0, 32'd2);
    check_ram("stall", exp_ram);

    // Abort in ACCEPT after two bytes, with a competing valid byte
    dn0 = n_done;
    start_session(4'd7, sc);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    exp_ram[0] = 8'h11; exp_ram[1] = 8'h22;
    wait_ready();
    abort = 1'b1; byte_valid = 1'b1; byte_in = 8'h55;
    @(negedge clk);
    abort = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_byte_kept", {24'd0, dut.byte_q}, 32'h22);
    repeat (4) @(negedge clk);
    check("abort_no_done", n_done - dn0, 32'd0);
    check("abort_idle", {31'd0, busy}, 32'd0);
    check_ram("abort", exp_ram);

    // Reset asserted while a write strobe is active
    start_session(4'd3, sc);
    send_byte(8'h77, 0);
    l0 = 0;
    while (!load && l0 < 10) begin
      @(negedge clk);
      l0++;
    end
    check("rst_saw_load", {31'd0, load}, 32'd1);
    clr_n = 1'b0;
    #1;
    check("rst_async_drop", {29'd0, load, data_oe, busy}, 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_needs_start", {31'd0, busy}, 32'd0);
    check_ram("rst_no_write", exp_ram);
    ld0 = n_load;
    start_session(4'd0, sc);
    send_byte(8'h5A, 0);
    exp_ram[0] = 8'h5A;
    wait_done();
    @(negedge clk);
    check("rst_new_loads", n_load - ld0, 32'd1);
    check_ram("rst_new", exp_ram);

    // Start pulsed mid-session is ignored
    ld0 = n_load; dn0 = n_done;
    start_session(4'd2, sc);
    send_byte(8'h90, 0);
    len = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h91, 0);
    send_byte(8'h92, 0);
    exp_ram[0] = 8'h90; exp_ram[1] = 8'h91; exp_ram[2] = 8'h92;
    wait_done();
    repeat (3) @(negedge clk);
    check("restart_loads", n_load - ld0, 32'd3);
    check("restart_done", n_done - dn0, 32'd1);
    check("restart_idle", {31'd0, busy}, 32'd0);
    check_ram("restart", exp_ram);

    // Randomized sessions with random host stalls
    for (int s = 0; s < 6; s++) begin
      logic [3:0] rl;
      rl  = 4'($urandom_range(0, 15));
      ld0 = n_load; dn0 = n_done;
      start_session(rl, sc);
      for (int k = 0; k <= int'(rl); k++) begin
        logic [7:0] b;
        b = 8'($urandom);
        exp_ram[k] = b;
        send_byte(b, $urandom_range(0, 3));
      end
      wait_done();
      @(negedge clk);
      check($sformatf("rnd%0d_loads", s), n_load - ld0, int'(rl) + 1);
      check($sformatf("rnd%0d_done", s), n_done - dn0, 32'd1);
      check_ram($sformatf("rnd%0d", s), exp_ram);
    end

    check("bus_invariants", n_bad, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
